// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit
// words and writes them to consecutive word addresses while stalling the CPU.
module instr_mem_loader #(
   parameter int          DEPTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          LEN_W     = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_i,
   output logic             byte_ready_o,
   output logic             we_o,
   output logic [31:0]      addr_o,
   output logic [31:0]      data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             cpu_hold_o
);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE,
      DONE
   } state_t;

   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   state_t           state, state_nx;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] idx;
   logic [1:0]       cnt;
   logic [31:0]      shreg;
   logic [31:0]      addr_q;
   logic [31:0]      data_q;
   logic             done_q;
   logic             err_q;

   logic             take;
   logic             start_go;
   logic             start_zero;
   logic             start_bad;
   logic             last;
   logic [31:0]      wr_addr;

   assign last    = (idx == len_q - LEN_W'(1));
   assign wr_addr = BASE_ADDR + (32'(idx) << 2);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      byte_ready_o = 1'b0;
      we_o         = 1'b0;
      take         = 1'b0;
      start_go     = 1'b0;
      start_zero   = 1'b0;
      start_bad    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start_i) begin
               if (len_i == '0) begin
                  start_zero = 1'b1;
                  state_nx   = DONE;
               end else if (len_i > DEPTH_L) begin
                  start_bad = 1'b1;
                  state_nx  = IDLE;
               end else begin
                  start_go = 1'b1;
                  state_nx = COLLECT;
               end
            end
         end
         COLLECT: begin
            byte_ready_o = 1'b1;
            take         = byte_valid_i;
            if (take && cnt == 2'd3) state_nx = WRITE;
         end
         WRITE: begin
            we_o     = 1'b1;
            state_nx = last ? DONE : COLLECT;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         len_q  <= '0;
         idx    <= '0;
         cnt    <= '0;
         shreg  <= '0;
         addr_q <= '0;
         data_q <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (start_go) begin
            len_q  <= len_i;
            idx    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
         end
         if (start_zero) begin
            done_q <= 1'b1;
            err_q  <= 1'b0;
         end
         if (start_bad) begin
            done_q <= 1'b0;
            err_q  <= 1'b1;
         end
         // cnt is 2 bits, so it wraps to 0 as the 4th byte moves us to WRITE
         if (take) begin
            shreg <= {shreg[23:0], byte_i};
            cnt   <= cnt + 2'd1;
         end
         if (we_o) begin
            addr_q <= wr_addr;
            data_q <= shreg;
            if (last) done_q <= 1'b1;
            else      idx    <= idx + LEN_W'(1);
         end
      end
   end

   // Outside a write cycle the bus keeps showing the last word written
   assign addr_o     = we_o ? wr_addr : addr_q;
   assign data_o     = we_o ? shreg : data_q;
   assign busy_o     = (state == COLLECT) || (state == WRITE);
   assign cpu_hold_o = busy_o;
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: streams known words and compares
// every memory write against hand-computed addresses and data.
module tb_instr_mem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [5:0]  len;
   logic        bvalid;
   logic [7:0]  bdata;
   logic        bready;
   logic        we;
   logic [31:0] addr;
   logic [31:0] data;
   logic        busy;
   logic        done;
   logic        err;
   logic        hold;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] words [32];
   logic [31:0] waddr [$];
   logic [31:0] wdata [$];

   instr_mem_loader #(
      .DEPTH     (32),
      .BASE_ADDR (32'h0000_0000),
      .LEN_W     (6)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .start_i      (start),
      .len_i        (len),
      .byte_valid_i (bvalid),
      .byte_i       (bdata),
      .byte_ready_o (bready),
      .we_o         (we),
      .addr_o       (addr),
      .data_o       (data),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .cpu_hold_o   (hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (we) begin
         waddr.push_back(addr);
         wdata.push_back(data);
         check("ready_in_write", 32'(bready), 32'd0);
         check("busy_in_write", 32'(busy), 32'd1);
         check("hold_in_write", 32'(hold), 32'd1);
      end
   end

   task automatic do_start(input logic [5:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int tries;
      bvalid = 1'b1;
      bdata  = b;
      tries  = 0;
      while (!bready && tries < 20) begin
         @(negedge clk);
         tries++;
      end
      if (!bready) check("ready_timeout", 32'(bready), 32'd1);
      @(negedge clk);
   endtask

   task automatic stream(input int first, input int last, input bit gap);
      for (int b = first; b <= last; b++) begin
         if (gap) begin
            bvalid = 1'b0;
            @(negedge clk);
         end
         send_byte(words[b / 4][31 - 8 * (b % 4) -: 8]);
      end
      bvalid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!done && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("done_seen", 32'(done), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
   endtask

   task automatic check_writes(input int n);
      check("n_writes", 32'(waddr.size()), 32'(n));
      for (int k = 0; k < n && k < waddr.size(); k++) begin
         check("wr_addr", waddr[k], 32'(4 * k));
         check("wr_data", wdata[k], words[k]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      len    = '0;
      bvalid = 1'b0;
      bdata  = '0;
      repeat (2) @(negedge clk);
      check("rst_we", 32'(we), 32'd0);
      check("rst_addr", addr, 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_ready", 32'(bready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // two words, continuous valid
      words[0] = 32'h8C01_0004;
      words[1] = 32'hAC02_0008;
      waddr.delete();
      wdata.delete();
      do_start(6'd2);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_hold", 32'(hold), 32'd1);
      stream(0, 7, 1'b0);
      wait_done();
      check_writes(2);
      check("t1_hold_end", 32'(hold), 32'd0);

      // same load, valid toggling
      waddr.delete();
      wdata.delete();
      do_start(6'd2);
      check("t2_done_clr", 32'(done), 32'd0);
      stream(0, 7, 1'b1);
      wait_done();
      check_writes(2);

      // zero length and oversize length
      waddr.delete();
      wdata.delete();
      do_start(6'd0);
      check("t3_done", 32'(done), 32'd1);
      check("t3_busy", 32'(busy), 32'd0);
      do_start(6'd33);
      check("t3_err", 32'(err), 32'd1);
      check("t3_done_clr", 32'(done), 32'd0);
      check("t3_busy2", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("t3_nwr", 32'(waddr.size()), 32'd0);

      // full-depth load
      for (int k = 0; k < 32; k++) words[k] = 32'h1000_0000 + 32'(k);
      waddr.delete();
      wdata.delete();
      do_start(6'd32);
      check("t4_err_clr", 32'(err), 32'd0);
      stream(0, 127, 1'b0);
      wait_done();
      check_writes(32);
      if (waddr.size() == 32) begin
         check("t4_last_addr", waddr[31], 32'h0000_007C);
         check("t4_last_data", wdata[31], 32'h1000_001F);
      end

      // asynchronous reset mid-word
      words[0] = 32'h1111_2222;
      words[1] = 32'h3333_4444;
      waddr.delete();
      wdata.delete();
      do_start(6'd3);
      stream(0, 5, 1'b0);
      check("t5_pre_nwr", 32'(waddr.size()), 32'd1);
      check("t5_pre_data", data, 32'h1111_2222);
      #2 rst_n = 1'b0;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_hold", 32'(hold), 32'd0);
      check("t5_addr", addr, 32'd0);
      check("t5_data", data, 32'd0);
      check("t5_ready", 32'(bready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      words[0] = 32'hDEAD_BEEF;
      waddr.delete();
      wdata.delete();
      do_start(6'd1);
      stream(0, 3, 1'b0);
      wait_done();
      check_writes(1);

      // start while busy is ignored
      words[0] = 32'h0123_4567;
      words[1] = 32'h89AB_CDEF;
      waddr.delete();
      wdata.delete();
      do_start(6'd2);
      stream(0, 2, 1'b0);
      do_start(6'd5);
      stream(3, 7, 1'b0);
      wait_done();
      repeat (10) @(negedge clk);
      check_writes(2);
      check("t6_done_hold", 32'(done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
